ahbl_master_cmd: RTL and testbench
==================================

Name: ahbl_master_cmd

Overview:
AHB-Lite initiator that turns a simple command stream into single AHB-Lite transfers: single beats only, HTRANS IDLE/NONSEQ. Commands are buffered in a small FIFO. Address and data phases are pipelined, so back-to-back commands overlap on the bus. Every transfer returns one in-order response carrying read data or an error flag. It sits between a CPU-side or DMA-side requester and the AHB-Lite interconnect feeding the team's register slaves.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
HCLK  input  1  clock; all logic on rising edge
HRESET  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO not full
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  32  transfer address
cmd_wdata  input  32  write data
cmd_size  input  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  32  read data; 0 for writes and errors
rsp_err  output  1  slave returned ERROR
busy  output  1  FIFO non-empty or data phase pending
HADDR  output  32  AHB address
HTRANS  output  2  IDLE = 2'b00, NONSEQ = 2'b10
HSIZE  output  3  {1'b0, size}
HWRITE  output  1  direction
HWDATA  output  32  write data, driven in data phase
HREADY  input  1  bus ready
HRDATA  input  32  read data
HRESP  input  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset (HRESET high at an edge) clears the FIFO, the data-phase register and the response register. Outputs after reset:
  - HTRANS = IDLE; HADDR, HSIZE, HWRITE, HWDATA = 0
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - busy = 0, cmd_ready = 1
- Reset mid-transfer drops all queued and in-flight commands and issues no responses for them.
- Push: occurs when cmd_valid & cmd_ready at an edge. cmd_ready = !full, with no combinational dependence on cmd_valid. When full, cmd_valid is ignored.
- Address phase: driven combinationally from the FIFO head.
  - FIFO non-empty and no cancel condition: HTRANS = NONSEQ, with HADDR/HSIZE/HWRITE from the head.
  - FIFO empty: HTRANS = IDLE and HADDR/HSIZE/HWRITE = 0.
  - HSIZE: cmd_size 3 maps to 3'b010. HADDR is passed through unaligned, with no checking.
- Address accept: NONSEQ & HREADY at an edge. The head is popped and its write flag, wdata and valid are loaded into the data-phase register. If HREADY = 0, the same head is held stable.
- Data phase: HWDATA = stored wdata when the data phase is a write, else 0. The data phase completes at the first edge with HREADY = 1.
- Zero-wait latency:
  - push at edge E0
  - NONSEQ in cycle E0..E1
  - data phase E1..E2
  - rsp_valid high in cycle E2..E3
  - Each wait state adds one cycle.
- Back-to-back: the next head is driven NONSEQ in the same cycle as the previous data phase. Sustained throughput is 1 transfer/cycle with HREADY = 1.
- Response: registered at data-phase completion and held for one cycle only; there is no backpressure.
  - OKAY read: rsp_rdata = HRDATA sampled at that edge.
  - OKAY write: rsp_rdata = 0.
  - rsp_err = HRESP.
- Error (two-cycle AHB response):
  - Cycle with HRESP = 1 and HREADY = 0 (cancel condition): HTRANS is forced to IDLE. The pending head is not popped.
  - Next cycle, HRESP = 1 and HREADY = 1: data phase completes and the response is rsp_err = 1, rsp_rdata = 0. The cancel is still active, so no address is accepted.
  - The cancelled head is re-issued as NONSEQ in the following cycle.
- Simultaneous push and pop: both occur and the count is unchanged. Pushing into an empty FIFO is visible on the bus in the next cycle, with no bypass.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are derived from a count of width clog2(FIFO_DEPTH)+1.
- busy = !empty | data_phase_valid.
- Responses are strictly in command order; exactly one response per accepted command.

Test Plan:
- Single write: cmd write addr 0x0100_0000, data 0xDEADBEEF, size 2, HREADY = 1 -> NONSEQ 1 cycle after push, HWDATA = 0xDEADBEEF the next cycle, rsp_valid 3 cycles after push with rsp_err = 0, rsp_rdata = 0.
- Read with wait states: read 0x0200_0000, slave holds HREADY = 0 for 2 data-phase cycles then returns 0x12345678 -> rsp_rdata = 0x12345678, rsp_valid exactly one cycle, HADDR stable meanwhile.
- Back-to-back: 4 writes then 4 reads (addresses 0x0, 0x0100_0000, 0x0200_0000, 0x0) against a register slave model -> NONSEQ on 8 consecutive cycles, reads return the written values in order; cmd_ready drops after the 4th push when FIFO_DEPTH = 4.
- Error: write 0x0, then read 0x0100_0000; slave gives ERROR on the write -> HTRANS = IDLE during the first error cycle, rsp_err = 1 for the write, the read is re-issued and completes OKAY.
- Size mapping: cmd_size 0, 1, 3 -> HSIZE 000, 001, 010.
- Reset mid-transfer: 3 commands queued, HRESET asserted while a data phase is in HREADY = 0 -> next cycle HTRANS = IDLE, busy = 0, cmd_ready = 1, no rsp_valid ever for the dropped commands.

Source files
------------

// File: rtl/ahbl_master_cmd.sv
// ahbl_master_cmd: command FIFO feeding single-beat AHB-Lite transfers (IDLE/NONSEQ),
// with pipelined address/data phases and exactly one in-order response per command.
module ahbl_master_cmd #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [1:0]  cmd_size,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        DP_IDLE  = 2'b00,
        DP_READ  = 2'b01,
        DP_WRITE = 2'b10
    } dp_state_t;

    // Command FIFO storage (no reset needed on the payload)
    logic              fifo_write_q [FIFO_DEPTH];
    logic [1:0]        fifo_size_q  [FIFO_DEPTH];
    logic [31:0]       fifo_addr_q  [FIFO_DEPTH];
    logic [31:0]       fifo_wdata_q [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    dp_state_t         dp_state_q, dp_state_d;
    logic [31:0]       dp_wdata_q, dp_wdata_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              dp_valid;
    logic              dp_write;
    logic              cancel;
    logic              addr_req;
    logic              head_write;
    logic [1:0]        head_size;
    logic [31:0]       head_addr;
    logic [31:0]       head_wdata;
    logic [1:0]        size_mapped;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;

    assign head_write = fifo_write_q[rd_ptr_q];
    assign head_size  = fifo_size_q[rd_ptr_q];
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_wdata = fifo_wdata_q[rd_ptr_q];

    assign dp_valid   = (dp_state_q != DP_IDLE);
    assign dp_write   = (dp_state_q == DP_WRITE);

    // ERROR from the slave spans two cycles; keep the bus idle across both so the
    // cancelled head is simply re-issued afterwards.
    assign cancel     = dp_valid && HRESP;
    assign addr_req   = !fifo_empty && !cancel;
    assign pop        = addr_req && HREADY;

    // Size code 3 has no meaning on this bus, so it is folded to word at push time.
    assign size_mapped = (cmd_size == 2'b11) ? 2'b10 : cmd_size;

    // Address phase straight from the FIFO head
    assign HTRANS = addr_req ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR  = fifo_empty ? 32'h0 : head_addr;
    assign HSIZE  = fifo_empty ? 3'b000 : {1'b0, head_size};
    assign HWRITE = !fifo_empty && head_write;
    assign HWDATA = dp_write ? dp_wdata_q : 32'h0;

    assign busy      = !fifo_empty || dp_valid;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge HCLK) begin
        if (push) begin
            fifo_write_q[wr_ptr_q] <= cmd_write;
            fifo_size_q[wr_ptr_q]  <= size_mapped;
            fifo_addr_q[wr_ptr_q]  <= cmd_addr;
            fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Data-phase tracker: advances only on HREADY, otherwise the current phase holds.
    always_comb begin
        dp_state_d = dp_state_q;
        dp_wdata_d = dp_wdata_q;
        if (HREADY) begin
            if (pop) begin
                dp_state_d = head_write ? DP_WRITE : DP_READ;
                dp_wdata_d = head_wdata;
            end else begin
                dp_state_d = DP_IDLE;
            end
        end
    end

    always_comb begin
        rsp_valid_d = dp_valid && HREADY;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        if (rsp_valid_d) begin
            rsp_err_d = HRESP;
            if (!dp_write && !HRESP) begin
                rsp_rdata_d = HRDATA;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            dp_state_q  <= DP_IDLE;
            dp_wdata_q  <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            dp_state_q  <= dp_state_d;
            dp_wdata_q  <= dp_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_ahbl_master_cmd.sv
// Bench for ahbl_master_cmd: scoreboard of expected responses, an AHB register-slave
// model with planned wait states / errors, and a response monitor.
module tb_ahbl_master_cmd;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [1:0]  cmd_size;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HRESP;

    ahbl_master_cmd #(.FIFO_DEPTH(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [3:0]  waits;
        logic        err;
    } cmd_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    int   checks = 0;
    int   errors = 0;
    int   rsp_seen = 0;
    cmd_t bus_q[$];
    rsp_t exp_q[$];
    logic [31:0] ref_mem   [logic [31:0]];
    logic [31:0] slave_mem [logic [31:0]];

    // slave model state
    bit          stall_bus = 1'b0;
    cmd_t        dp;
    bit          dp_active = 1'b0;
    int          dp_waits = 0;
    bit          err_stage = 1'b0;
    bit          held_valid = 1'b0;
    logic [31:0] held_addr;
    int          run = 0;
    int          max_run = 0;

    logic [31:0] addr_tbl [6] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0100,
                                   32'h0100_0000, 32'h0200_0000, 32'h8000_0010};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : 32'h0;
    endfunction

    // Called at a falling edge; returns at the falling edge after the push edge.
    task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input int waits, input logic err);
        int   budget = 200;
        cmd_t c;
        rsp_t r;
        while (!cmd_ready && budget > 0) begin
            @(negedge HCLK);
            budget--;
        end
        chk("push_ready", {31'b0, cmd_ready}, 32'h1);
        if (!cmd_ready) return;
        c.write = w; c.addr = a; c.wdata = d; c.size = (s == 2'b11) ? 2'b10 : s;
        c.waits = 4'(waits); c.err = err;
        bus_q.push_back(c);
        r.err   = err;
        r.rdata = (!w && !err) ? ref_rd(a) : 32'h0;
        if (w && !err) ref_mem[a] = d;
        exp_q.push_back(r);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_size = s;
        @(posedge HCLK);
        @(negedge HCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int  budget = 2000;
        bit  idle = 1'b0;
        while (!idle && budget > 0) begin
            @(negedge HCLK);
            #2;
            idle = (exp_q.size() == 0) && !busy;
            budget--;
        end
        chk(name, {31'b0, idle}, 32'h1);
    endtask

    // AHB slave: decides HREADY/HRESP at each falling edge, then observes what the
    // master presents for the coming rising edge.
    always @(negedge HCLK) begin
        if (HRESET) begin
            dp_active = 1'b0; err_stage = 1'b0; held_valid = 1'b0;
            HREADY = 1'b1; HRESP = 1'b0;
        end else begin
            HRDATA = $urandom;
            if (stall_bus) begin
                HREADY = 1'b0; HRESP = 1'b0;
            end else if (!dp_active) begin
                HREADY = 1'b1; HRESP = 1'b0;
            end else if (dp.err) begin
                HRESP = 1'b1; HREADY = err_stage; err_stage = 1'b1;
            end else if (dp_waits > 0) begin
                HREADY = 1'b0; HRESP = 1'b0; dp_waits--;
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
                if (!dp.write) HRDATA = slave_rd(dp.addr);
            end
            #1;
            if (HRESP) chk("cancel_idle", {30'b0, HTRANS}, 32'h0);
            if (held_valid) begin
                chk("hold_trans", {30'b0, HTRANS}, 32'h2);
                chk("hold_addr", HADDR, held_addr);
            end
            held_valid = 1'b0;
            if (HREADY) begin
                if (dp_active) begin
                    chk("hwdata", HWDATA, dp.write ? dp.wdata : 32'h0);
                    if (dp.write && !dp.err) slave_mem[dp.addr] = dp.wdata;
                end
                dp_active = 1'b0;
                if (HTRANS == 2'b10) begin
                    if (bus_q.size() == 0) begin
                        chk("unexpected_nonseq", {31'b0, bus_q.size() != 0}, 32'h1);
                    end else begin
                        dp = bus_q.pop_front();
                        chk("haddr", HADDR, dp.addr);
                        chk("hwrite", {31'b0, HWRITE}, {31'b0, dp.write});
                        chk("hsize", {29'b0, HSIZE}, {30'b0, dp.size});
                        dp_active = 1'b1; dp_waits = int'(dp.waits); err_stage = 1'b0;
                        run++;
                        if (run > max_run) max_run = run;
                    end
                end else begin
                    run = 0;
                end
            end else begin
                run = 0;
                if (HTRANS == 2'b10 && !HRESP) begin
                    held_valid = 1'b1; held_addr = HADDR;
                end
            end
        end
    end

    // Response monitor / scoreboard
    always @(negedge HCLK) begin
        rsp_t r;
        #1;
        if (!HRESET && rsp_valid) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {31'b0, exp_q.size() != 0}, 32'h1);
            end else begin
                r = exp_q.pop_front();
                $display("rsp %0d: err=%0d rdata=0x%08h (want err=%0d rdata=0x%08h)",
                         rsp_seen, rsp_err, rsp_rdata, r.err, r.rdata);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, r.err});
                chk("rsp_rdata", rsp_rdata, r.rdata);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_before;
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_size = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        repeat (3) @(posedge HCLK);
        #3 HRESET = 1'b0;
        @(negedge HCLK); #2;
        chk("rst_htrans", {30'b0, HTRANS}, 32'h0);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hsize", {29'b0, HSIZE}, 32'h0);
        chk("rst_hwrite", {31'b0, HWRITE}, 32'h0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);

        // single write, zero-wait latency
        push(1'b1, 32'h0100_0000, 32'hDEAD_BEEF, 2'd2, 0, 1'b0);
        #2;
        chk("sw_nonseq", {30'b0, HTRANS}, 32'h2);
        chk("sw_haddr", HADDR, 32'h0100_0000);
        @(negedge HCLK); #2;
        chk("sw_hwdata", HWDATA, 32'hDEAD_BEEF);
        @(negedge HCLK); #2;
        chk("sw_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("sw_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge HCLK); #2;
        chk("sw_rsp_drop", {31'b0, rsp_valid}, 32'h0);
        wait_idle("idle_sw");

        // read with two wait states
        push(1'b1, 32'h0200_0000, 32'h1234_5678, 2'd2, 0, 1'b0);
        wait_idle("idle_wr");
        push(1'b0, 32'h0200_0000, 32'h0, 2'd2, 2, 1'b0);
        for (int i = 0; i < 20 && !rsp_valid; i++) begin
            @(negedge HCLK); #2;
        end
        chk("wr_rsp_seen", {31'b0, rsp_valid}, 32'h1);
        chk("wr_rdata", rsp_rdata, 32'h1234_5678);
        @(negedge HCLK); #2;
        chk("wr_rsp_one_cycle", {31'b0, rsp_valid}, 32'h0);
        wait_idle("idle_rd");

        // back-to-back: fill the FIFO behind a stalled bus, then stream
        stall_bus = 1'b1;
        push(1'b1, 32'h0000_0000, 32'hA0A0_0001, 2'd2, 0, 1'b0);
        push(1'b1, 32'h0100_0000, 32'hB0B0_0002, 2'd2, 0, 1'b0);
        push(1'b1, 32'h0200_0000, 32'hC0C0_0003, 2'd2, 0, 1'b0);
        push(1'b1, 32'h0000_0000, 32'hD0D0_0004, 2'd2, 0, 1'b0);
        #2;
        chk("b2b_full_ready", {31'b0, cmd_ready}, 32'h0);
        max_run = 0;
        stall_bus = 1'b0;
        push(1'b0, 32'h0000_0000, 32'h0, 2'd2, 0, 1'b0);
        push(1'b0, 32'h0100_0000, 32'h0, 2'd2, 0, 1'b0);
        push(1'b0, 32'h0200_0000, 32'h0, 2'd2, 0, 1'b0);
        push(1'b0, 32'h0000_0000, 32'h0, 2'd2, 0, 1'b0);
        wait_idle("idle_b2b");
        chk("b2b_nonseq_run", 32'(max_run), 32'd8);

        // ERROR on a write, following read re-issued
        push(1'b1, 32'h0000_0000, 32'hCAFE_F00D, 2'd2, 0, 1'b1);
        push(1'b0, 32'h0100_0000, 32'h0, 2'd2, 0, 1'b0);
        wait_idle("idle_err");

        // size mapping and unaligned pass-through
        push(1'b0, 32'h0000_0013, 32'h0, 2'd0, 0, 1'b0);
        push(1'b0, 32'h0000_0102, 32'h0, 2'd1, 0, 1'b0);
        push(1'b0, 32'h0000_0100, 32'h0, 2'd3, 0, 1'b0);
        wait_idle("idle_size");

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            logic        w;
            logic [31:0] a;
            int          waits;
            repeat ($urandom_range(0, 2)) @(negedge HCLK);
            w     = 1'($urandom_range(0, 1));
            a     = addr_tbl[$urandom_range(0, 5)];
            waits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            push(w, a, $urandom, 2'($urandom_range(0, 3)), waits,
                 ($urandom_range(0, 7) == 0));
        end
        wait_idle("idle_rand");

        // reset while a data phase is stalled
        push(1'b0, 32'h0000_0004, 32'h0, 2'd2, 10, 1'b0);
        push(1'b0, 32'h0000_0100, 32'h0, 2'd2, 0, 1'b0);
        push(1'b0, 32'h0200_0000, 32'h0, 2'd2, 0, 1'b0);
        chk("rst_mid_dp_stalled", {31'b0, dp_active && (HREADY == 1'b0)}, 32'h1);
        @(posedge HCLK);
        #3 HRESET = 1'b1;
        exp_q.delete();
        bus_q.delete();
        @(posedge HCLK);
        #3 HRESET = 1'b0;
        @(negedge HCLK); #2;
        chk("rst_mid_htrans", {30'b0, HTRANS}, 32'h0);
        chk("rst_mid_busy", {31'b0, busy}, 32'h0);
        chk("rst_mid_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        seen_before = rsp_seen;
        repeat (20) @(negedge HCLK);
        #2;
        chk("rst_mid_no_rsp", 32'(rsp_seen), 32'(seen_before));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
